nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning the operand width in 4-bit nibbles (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port x, input, 4*NIBBLES, operand A.
REQ-006 The block SHALL have port y, input, 4*NIBBLES, operand B.
REQ-007 The block SHALL have port cIn, input, 1, the carry into nibble 0.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress (states ADD and DONE).
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port s, output, 4*NIBBLES, the registered sum.
REQ-011 The block SHALL have port cOut, output, 1, the carry out of the top nibble.
REQ-012 The block SHALL have port v, output, 1, the two's-complement overflow flag (see Configuration).

Function
REQ-013 The block SHALL compute s, cOut = x + y + cIn one nibble per cycle, LSB nibble first, through a single instance of the team's 4-bit CLA_Add4 (ports x, y, cIn, s, cOut).
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
- IDLE -> ADD when start=1: latch x, y and cIn into operand registers; set nibble index k=0; clear s.
- ADD: each cycle, drive nibble k of the latched operands and the carry register into CLA_Add4; write the sum nibble into s[4k+3:4k]; load the carry register with the adder cOut; increment k.
- ADD -> DONE on the cycle nibble NIBBLES-1 is written.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 If start is sampled at edge E0, nibble k SHALL be registered at edge E(k+1), and done SHALL be high for exactly the cycle following edge E(NIBBLES).
REQ-016 cOut SHALL be registered when the final nibble is written; s, cOut and v SHALL then hold until the next accepted start.
REQ-017 start SHALL be ignored in ADD and DONE; x, y and cIn changes during an operation SHALL NOT affect the result.
REQ-018 A start asserted in the same cycle the block returns to IDLE SHALL be accepted at the next edge, giving back-to-back operations with one IDLE cycle between them.
REQ-019 With NIBBLES=1 the block SHALL spend exactly one cycle in ADD.
REQ-020 Wrap-around SHALL be modulo 2^(4*NIBBLES), with the carry reported only on cOut.

Reset
REQ-021 Asserting rst SHALL force, without waiting for clk:
- state=IDLE, k=0, carry register=0;
- busy=0, done=0, s=0, cOut=0, v=0.
REQ-022 Reset during ADD or DONE SHALL abort the operation with no done pulse.
REQ-023 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-024 With macro NIBBLE_SERIAL_ADDER_OVERFLOW_EN defined, v SHALL be set at the final nibble to (A_msb == B_msb) and (S_msb != A_msb), using the latched operands.
REQ-025 Without NIBBLE_SERIAL_ADDER_OVERFLOW_EN, v SHALL be constant 0 and no overflow logic SHALL be synthesized; all other behaviour is unchanged.

Verification (NIBBLES=4)
REQ-026 The bench SHALL cover: x=FFFE, y=0001, cIn=0, start at E0 -> s=FFFF, cOut=0, done high only in the cycle after E4.
REQ-027 The bench SHALL cover: x=FFFF, y=0001, cIn=0 -> s=0000, cOut=1 (carry ripples across every nibble boundary); x=0000, y=0000, cIn=1 -> s=0001, cOut=0.
REQ-028 The bench SHALL cover: x=7FFF, y=0001 -> s=8000, cOut=0, v=1 with the macro defined and v=0 without it; x=8000, y=8000 -> s=0000, cOut=1, v=1 with the macro defined.
REQ-029 The bench SHALL cover: start=1 with x=1111, y=2222, then start held with x=AAAA during ADD -> exactly one result s=3333 and exactly one done pulse.
REQ-030 The bench SHALL cover: rst pulsed asynchronously between E2 and E3 of an operation -> busy, s, cOut and v read 0 immediately, no done pulse, and the next start completes normally.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: computes x + y + cIn one nibble per cycle through a single CLA_Add4.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to build the two's-complement overflow flag v.

module CLA_Add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cIn,
  output logic [3:0] s,
  output logic       cOut
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Carry lookahead from generate/propagate terms
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = cIn;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    cOut = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  input  logic                   cIn,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cOut,
  output logic                   v
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      add_s;
  logic            add_c;
  logic            last_nib;

  CLA_Add4 u_cla (
    .x    (a_q[{k_q, 2'b00} +: 4]),
    .y    (b_q[{k_q, 2'b00} +: 4]),
    .cIn  (carry_q),
    .s    (add_s),
    .cOut (add_c)
  );

  assign last_nib = (k_q == KW'(NIBBLES - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic v_q, v_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  // Overflow from the latched operand sign bits and the final sum nibble's MSB
  always_comb begin
    v_d = v_q;
    if (state_q == IDLE && start)
      v_d = 1'b0;
    else if (state_q == ADD && last_nib)
      v_d = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
  end

  assign v = v_q;
`else
  assign v = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = x;
          b_d     = y;
          carry_d = cIn;
          k_d     = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        s_d[{k_q, 2'b00} +: 4] = add_s;
        carry_d = add_c;
        k_d     = k_q + KW'(1);
        if (last_nib) begin
          k_d     = '0;
          cout_d  = add_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cOut = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): vector table, random ops, hold and reset-abort sequences.
module tb_nibble_serial_adder;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x, y, s;
  logic         cin, busy, done, cout, v;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cIn(cin),
    .busy(busy), .done(done), .s(s), .cOut(cout), .v(v)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] es;
    logic         ec;
    logic         ov;
  } vec_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    res_t r;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = OV_EN && (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after E5 (IDLE again)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input res_t e, input bit hold, input string tag);
    res_t got;
    x = a; y = b; cin = c; start = 1'b1;
    sb_q.push_back(e);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) x = 16'hAAAA;
        else begin
          start = 1'b0; x = ~a; y = ~b; cin = ~c;
        end
      end
      if (i == 4) start = 1'b0;
      check({tag, " done timing"}, 32'(done), 32'(i == 4));
      check({tag, " busy"}, 32'(busy), 32'(i <= 4));
      if (done) begin
        if (sb_q.size() == 0) begin
          check({tag, " unexpected done"}, 32'(1), 32'(0));
        end else begin
          got = sb_q.pop_front();
          check({tag, " s"}, 32'(s), 32'(got.s));
          check({tag, " cOut"}, 32'(cout), 32'(got.c));
          check({tag, " v"}, 32'(v), 32'(got.v));
        end
      end
    end
    check({tag, " s hold"}, 32'(s), 32'(e.s));
    check({tag, " scoreboard empty"}, 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    vec_t vecs[8];
    res_t e;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{16'hFFFE, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset s", 32'(s), 32'(0));
    check("reset cOut", 32'(cout), 32'(0));
    check("reset v", 32'(v), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Table vectors run back-to-back with a single IDLE cycle between them
    for (int i = 0; i < 8; i++) begin
      e.s = vecs[i].es;
      e.c = vecs[i].ec;
      e.v = OV_EN && vecs[i].ov;
      run_op(vecs[i].x, vecs[i].y, vecs[i].cin, e, 1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc, model(ra, rb, rc), 1'b0, $sformatf("rand%0d", i));
    end

    // start held through the operation with x changing: one result, one done
    e.s = 16'h3333; e.c = 1'b0; e.v = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0, e, 1'b1, "hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold no extra done", 32'(done), 32'(0));
    end

    // Asynchronous reset between E2 and E3 aborts the operation
    x = 16'h1234; y = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort s", 32'(s), 32'(0));
    check("abort cOut", 32'(cout), 32'(0));
    check("abort v", 32'(v), 32'(0));
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'(0));
      check("abort idle", 32'(busy), 32'(0));
    end
    run_op(16'h7FFF, 16'h0001, 1'b0, model(16'h7FFF, 16'h0001, 1'b0), 1'b0, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
